datapath_seq_ctrl: RTL

Sequencing controller for the three-stage bit-update datapath (clear stage D1, bit-write stage D2, display-publish stage D3). Accepts clear, write-bit and commit commands over a valid/ready handshake and buffers them in a small FIFO. Executes them in order as single-cycle d1_en / d2_en / d3_en pulses with bit_index / bit_value driven alongside. Auto-commits pending writes to the display stage after an idle timeout.

---
 rtl/ctrl_pkg.sv | 27 ++
 rtl/cmd_fifo.sv | 49 ++++
 rtl/datapath_seq_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared types for the datapath sequencing controller: command opcodes,
// controller states and the default command word layout.
package ctrl_pkg;

  localparam int IDX_W_DEF = 3;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_COMMIT = 2'b10,
    OP_RSVD   = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WRITE,
    ST_COMMIT
  } state_e;

  typedef struct packed {
    cmd_op_e              op;
    logic [IDX_W_DEF-1:0] index;
    logic                 value;
  } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO. Pointers carry one extra wrap bit so full and
// empty fall out of a plain pointer comparison.
module cmd_fifo
  import ctrl_pkg::*;
#(
  parameter type cmd_type = cmd_t,
  parameter int  DEPTH    = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  cmd_type push_data,
  input  logic    pop,
  output cmd_type head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  cmd_type       mem [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/datapath_seq_ctrl.sv
// Sequencing controller for the clear / bit-write / publish datapath: buffers
// commands, issues one-cycle stage enables in order and auto-commits when idle.
module datapath_seq_ctrl
  import ctrl_pkg::*;
#(
  parameter int IDX_W          = IDX_W_DEF,
  parameter int FIFO_DEPTH     = 4,
  parameter int COMMIT_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [IDX_W-1:0] cmd_index,
  input  logic             cmd_value,
  output logic             d1_en,
  output logic             d2_en,
  output logic             d3_en,
  output logic [IDX_W-1:0] bit_index,
  output logic             bit_value,
  output logic             busy,
  output logic             dirty,
  output logic             err_op
);

  localparam int TIMER_W = (COMMIT_TIMEOUT > 1) ? $clog2(COMMIT_TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(COMMIT_TIMEOUT - 1);

  typedef struct packed {
    cmd_op_e          op;
    logic [IDX_W-1:0] index;
    logic             value;
  } cmd_word_t;

  cmd_word_t          push_cmd;
  cmd_word_t          head_cmd;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               expire;
  logic               ready_q;
  state_e             state;
  logic [TIMER_W-1:0] timer;

  assign cmd_ready = ready_q && !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign push_cmd  = '{op: cmd_op_e'(cmd_op), index: cmd_index, value: cmd_value};

  // Auto-commit outranks a waiting command so pending writes are published first.
  assign expire = (state == ST_IDLE) && dirty && (timer == TIMER_LAST);
  assign pop    = (state == ST_IDLE) && !fifo_empty && !expire;
  assign busy   = (state != ST_IDLE) || !fifo_empty;

  cmd_fifo #(
    .cmd_type (cmd_word_t),
    .DEPTH    (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_cmd),
    .pop       (pop),
    .head      (head_cmd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Each execute state lasts one cycle and raises its enable on the way back to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      timer     <= '0;
      ready_q   <= 1'b0;
      d1_en     <= 1'b0;
      d2_en     <= 1'b0;
      d3_en     <= 1'b0;
      err_op    <= 1'b0;
      dirty     <= 1'b0;
      bit_index <= '0;
      bit_value <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      d1_en   <= 1'b0;
      d2_en   <= 1'b0;
      d3_en   <= 1'b0;
      err_op  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (expire) begin
            state <= ST_COMMIT;
            timer <= '0;
          end else if (pop) begin
            case (head_cmd.op)
              OP_WRITE: begin
                state     <= ST_WRITE;
                bit_index <= head_cmd.index;
                bit_value <= head_cmd.value;
              end
              OP_CLEAR:  state  <= ST_CLEAR;
              OP_COMMIT: state  <= ST_COMMIT;
              OP_RSVD:   err_op <= 1'b1;
            endcase
          end else if (dirty) begin
            timer <= timer + TIMER_W'(1);
          end else begin
            timer <= '0;
          end
        end
        ST_CLEAR: begin
          d1_en <= 1'b1;
          dirty <= 1'b1;
          timer <= '0;
          state <= ST_IDLE;
        end
        ST_WRITE: begin
          d2_en <= 1'b1;
          dirty <= 1'b1;
          timer <= '0;
          state <= ST_IDLE;
        end
        ST_COMMIT: begin
          d3_en <= 1'b1;
          dirty <= 1'b0;
          timer <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
